// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - register offsets, status bit positions and FSM states for uart_tx_dev
package uart_pkg;

    localparam logic [1:0] UART_TXDATA = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;
    localparam logic [1:0] UART_DIV    = 2'd2;

    localparam int STATUS_FULL      = 0;
    localparam int STATUS_EMPTY     = 1;
    localparam int STATUS_BUSY      = 2;
    localparam int STATUS_COUNT_LSB = 4;

    typedef logic [1:0] uart_state_t;

    localparam uart_state_t ST_IDLE  = 2'd0;
    localparam uart_state_t ST_START = 2'd1;
    localparam uart_state_t ST_DATA  = 2'd2;
    localparam uart_state_t ST_STOP  = 2'd3;

    // The STATUS count field is only 4 bits wide; deeper FIFOs show 15.
    function automatic logic [3:0] sat_count4(input int unsigned n);
        return (n > 15) ? 4'd15 : 4'(n);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with extra-MSB pointers, shared by TX and future RX paths
module sync_fifo #(
    parameter int Width = 8,
    parameter int Depth = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [Width-1:0]         wdata_i,
    output logic [Width-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int AW = $clog2(Depth);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [Width-1:0] mem_q [Depth];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // Full is taken from registered pointers, so a same-cycle pop never frees room for a push.
    assign do_push  = push_i && !full_o;
    assign do_pop   = pop_i && !empty_o;
    assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_tx_dev.sv
// rtl/uart_tx_dev.sv - bus-attached 8N1 UART transmitter with TX FIFO, status/divider registers and drain interrupt
module uart_tx_dev
    import uart_pkg::*;
#(
    parameter int          DataWidth    = 32,
    parameter int          AddressWidth = 32,
    parameter int          FifoDepth    = 8,
    parameter logic [15:0] DivReset     = 16'd867
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [3:0]              be_i,
    input  logic [AddressWidth-1:0] addr_i,
    input  logic [DataWidth-1:0]    wdata_i,
    output logic                    rvalid_o,
    output logic [DataWidth-1:0]    rdata_o,
    output logic                    err_o,
    output logic                    txd_o,
    output logic                    tx_empty_intr_o
);

    localparam int CW = $clog2(FifoDepth) + 1;

    logic [1:0]           reg_sel;
    logic                 fifo_push, fifo_pop;
    logic                 fifo_full, fifo_empty;
    logic [7:0]           fifo_rdata;
    logic [CW-1:0]        fifo_count;
    logic [DataWidth-1:0] status_word;
    logic [DataWidth-1:0] resp_data;
    logic                 resp_err;
    logic                 div_we;

    logic                 rvalid_q;
    logic [DataWidth-1:0] rdata_q;
    logic                 err_q;
    logic [15:0]          div_q, div_d;

    uart_state_t          state_q, state_d;
    logic [7:0]           shift_q, shift_d;
    logic [15:0]          bit_div_q, bit_div_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic                 txd_q, txd_d;
    logic                 intr_q;
    logic                 bit_end;

    logic                 unused_inputs;

    assign reg_sel       = addr_i[3:2];
    assign unused_inputs = ^{addr_i, wdata_i, be_i[3:2]};

    sync_fifo #(
        .Width (8),
        .Depth (FifoDepth)
    ) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (wdata_i[7:0]),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        status_word = '0;
        status_word[STATUS_FULL]  = fifo_full;
        status_word[STATUS_EMPTY] = fifo_empty;
        status_word[STATUS_BUSY]  = (state_q != ST_IDLE);
        status_word[STATUS_COUNT_LSB +: 4] = sat_count4(32'(fifo_count));
    end

    always_comb begin
        fifo_push = 1'b0;
        div_we    = 1'b0;
        resp_err  = 1'b0;
        resp_data = '0;
        if (req_i) begin
            if (we_i) begin
                case (reg_sel)
                    UART_TXDATA: begin
                        if (be_i[0]) begin
                            if (fifo_full) resp_err  = 1'b1;
                            else           fifo_push = 1'b1;
                        end
                    end
                    UART_DIV: begin
                        if (be_i[1:0] == 2'b11) div_we   = 1'b1;
                        else                    resp_err = 1'b1;
                    end
                    default: resp_err = 1'b1;
                endcase
            end else begin
                case (reg_sel)
                    UART_TXDATA: resp_data = '0;
                    UART_STATUS: resp_data = status_word;
                    UART_DIV:    resp_data = {{(DataWidth-16){1'b0}}, div_q};
                    default:     resp_err  = 1'b1;
                endcase
            end
        end
    end

    assign div_d = div_we ? wdata_i[15:0] : div_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            div_q    <= DivReset;
        end else begin
            rvalid_q <= req_i;
            rdata_q  <= resp_data;
            err_q    <= resp_err;
            div_q    <= div_d;
        end
    end

    assign bit_end = (cnt_q == bit_div_q);

    // bit_div is captured at frame start so DIV writes never stretch a frame in flight.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_div_d = bit_div_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        txd_d     = txd_q;
        fifo_pop  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_d   = fifo_rdata;
                    bit_div_d = div_q;
                    cnt_d     = '0;
                    txd_d     = 1'b0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    txd_d   = shift_q[0];
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_div_q <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            txd_q     <= 1'b1;
            intr_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_div_q <= bit_div_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            txd_q     <= txd_d;
            intr_q    <= fifo_empty && (state_q == ST_IDLE);
        end
    end

    assign rvalid_o        = rvalid_q;
    assign rdata_o         = rdata_q;
    assign err_o           = err_q;
    assign txd_o           = txd_q;
    assign tx_empty_intr_o = intr_q;

endmodule
